// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;
  localparam logic [6:0] SEG7_0     = 7'b1000000;
  localparam logic [6:0] SEG7_1     = 7'b1111001;
  localparam logic [6:0] SEG7_2     = 7'b0100100;
  localparam logic [6:0] SEG7_3     = 7'b0110000;
  localparam logic [6:0] SEG7_4     = 7'b0011001;
  localparam logic [6:0] SEG7_5     = 7'b0010010;
  localparam logic [6:0] SEG7_6     = 7'b0000010;
  localparam logic [6:0] SEG7_7     = 7'b1111000;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0010000;
  localparam logic [6:0] SEG7_A     = 7'b0001000;
  localparam logic [6:0] SEG7_B     = 7'b0000011;
  localparam logic [6:0] SEG7_C     = 7'b1000110;
  localparam logic [6:0] SEG7_D     = 7'b0100001;
  localparam logic [6:0] SEG7_E     = 7'b0000110;
  localparam logic [6:0] SEG7_F     = 7'b0001110;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Element i is the glyph for nibble i.
  localparam logic [15:0][6:0] SEG7_GLYPHS = {
    SEG7_F, SEG7_E, SEG7_D, SEG7_C, SEG7_B, SEG7_A, SEG7_9, SEG7_8,
    SEG7_7, SEG7_6, SEG7_5, SEG7_4, SEG7_3, SEG7_2, SEG7_1, SEG7_0
  };

  typedef enum logic {LOCKED, SETTLE} seg7_state_t;

  typedef struct packed {
    logic [3:0] nibble;
    logic       legal;
    logic       is_blank;
  } seg7_dec_t;
endpackage

// File: rtl/seg7_lookup.sv
// Combinational pattern -> {nibble, legal, is_blank} decode against the hex glyph table.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output seg7_dec_t  dec
);
  logic [15:0] hit;

  for (genvar i = 0; i < 16; i++) begin : g_hit
    assign hit[i] = (pattern == SEG7_GLYPHS[i]);
  end

  // Glyphs are unique, so at most one hit bit is set.
  always_comb begin
    dec          = '0;
    dec.is_blank = (pattern == SEG7_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (hit[i]) begin
        dec.nibble = 4'(i);
        dec.legal  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg7_capture.sv
// Seven-segment readback: sync, stability filter, decode, commit.
// Optional saturating illegal-commit counter under SEG7_CAP_ERRCNT_EN.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       update,
  output logic       blank,
  output logic       err
`ifdef SEG7_CAP_ERRCNT_EN
  ,output logic [7:0] err_cnt
`endif
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [6:0]      s1, s2;
  logic [6:0]      cand, cand_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  seg7_state_t     state, state_nxt;
  logic            commit;
  logic            bad_commit;
  seg7_dec_t       dec;

  seg7_lookup u_lookup (.pattern(cand), .dec(dec));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= SEG7_BLANK;
      s2 <= SEG7_BLANK;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOCKED;
      cand  <= SEG7_BLANK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Any disagreement restarts the window; commit happens on the edge that
  // sees the STABLE_CYCLES-th matching sample.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    if (s2 != cand) begin
      cand_nxt  = s2;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_LAST) begin
        commit    = 1'b1;
        state_nxt = LOCKED;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign bad_commit = commit && !dec.legal && !dec.is_blank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      blank      <= 1'b1;
      update     <= 1'b0;
      err        <= 1'b0;
    end else begin
      update <= 1'b0;
      err    <= 1'b0;
      if (commit) begin
        if (dec.legal) begin
          data_out   <= dec.nibble;
          data_valid <= 1'b1;
          blank      <= 1'b0;
          update     <= !data_valid || (dec.nibble != data_out);
        end else if (dec.is_blank) begin
          data_valid <= 1'b0;
          blank      <= 1'b1;
        end else begin
          data_valid <= 1'b0;
          blank      <= 1'b0;
          err        <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7_CAP_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_cnt <= '0;
    else if (bad_commit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_bad;
  assign unused_bad = bad_commit;
`endif
endmodule

// File: doc/seg7_capture.md
# seg7_capture

Receive side of the team's seven-segment display bus: samples an asynchronous active-low segment pattern and recovers the hex nibble that produced it. Samples are synchronised, filtered for stability and decoded against the 16-glyph hex table. The block emits the nibble with valid, update and error indications. It sits between a display-driving counter and any logic that must read back the displayed value (checkers, loopback tests, scoreboards).

## Interface
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before commit; legal range 1..255
- clk  in  1  sampling clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- seg_in  in  7  segment pattern {g,f,e,d,c,b,a}, active-low, asynchronous to clk
- data_out  out  4  last committed legal nibble
- data_valid  out  1  level; data_out reflects the currently committed pattern
- update  out  1  one-cycle pulse when a legal nibble is committed that differs from data_out or when data_valid was 0
- blank  out  1  level; committed pattern is 7'h7F (all segments off)
- err  out  1  one-cycle pulse when an illegal pattern is committed
- err_cnt  out  8  saturating illegal-commit count (only with SEG7_CAP_ERRCNT_EN)

## Operation
- Hex table (pattern->nibble): 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, B:0000011, C:1000110, D:0100001, E:0000110, F:0001110; 7'h7F = blank; all other codes are illegal.
- Two-flop synchroniser on seg_in, giving s2.
- Candidate register cand and stability counter cnt, width $clog2(STABLE_CYCLES+1).
- State LOCKED, on s2 != cand: cand<=s2, cnt<=0, go to SETTLE.
- State SETTLE, on s2 != cand: cand<=s2, cnt<=0, stay in SETTLE.
- State SETTLE, on s2 == cand and cnt < STABLE_CYCLES-1: cnt++.
- State SETTLE, on s2 == cand and cnt == STABLE_CYCLES-1: commit cand, go to LOCKED.
- Commit of a legal nibble: data_out<=nibble, data_valid<=1, blank<=0, update per the rule in the port list.
- Commit of blank: data_valid<=0, blank<=1, data_out held, no update.
- Commit of an illegal code: data_valid<=0, blank<=0, data_out held, err pulse.
- Re-committing the same legal nibble after a glitch that settles back gives no update pulse.
- A glitch shorter than STABLE_CYCLES samples restarts SETTLE and never commits.

## Timing
- Reset values: sync flops 7'h7F, cand 7'h7F, cnt 0, state LOCKED, data_out 0, data_valid 0, blank 1, update 0, err 0, err_cnt 0. No commit follows reset while the input stays blank.
- Latency: seg_in stable before edge 0 gives sync at edges 1-2, cand load at edge 3, commit at edge 3+STABLE_CYCLES. update, err and data_* are visible after that edge.
- update and err never assert in the same cycle; each is exactly one cycle wide.
- Reset asserted mid-SETTLE discards the candidate; all outputs return to reset values immediately (asynchronously).
- Input change on the commit edge: the commit uses cand, and s2 starts a new SETTLE on the next edge.

## Configuration
- SEG7_CAP_ERRCNT_EN defined: the err_cnt port exists. It increments on each err pulse, saturates at 255, and is cleared only by reset.
- SEG7_CAP_ERRCNT_EN undefined: no err_cnt port or register; err pulse behaviour is unchanged.

## Structure
- seg7_pkg: the 16 glyph constants, SEG7_BLANK = 7'h7F, and the state enum {LOCKED, SETTLE}.
- Sub-module seg7_lookup: combinational pattern -> {nibble, legal, is_blank}, built from seg7_pkg constants.
- seg7_capture holds the synchroniser, filter FSM, output registers and optional error counter.

## Test plan
- Reset, then seg_in=7'h7F for 20 cycles -> blank=1, data_valid=0, no update, no err.
- seg_in 7'h7F->7'b0100100 (STABLE_CYCLES=4) -> update pulses after edge 7, data_out=2, data_valid=1, blank=0.
- Hold 2, 2-cycle glitch to 7'b0000000, return to 2 -> no commit of 8, no update, data_out stays 2.
- seg_in=7'b1010101 (illegal) held 10 cycles -> single err pulse, data_valid=0, data_out held at 2; with macro err_cnt=1.
- Sweep 0..F, each held 8 cycles -> 16 update pulses, data_out matches the table each time.
- Mid-SETTLE toward 7'b0001110 with reset asserted for 1 cycle -> outputs at reset values; after release with input held, data_out=F committed STABLE_CYCLES+3 edges later.
